// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_pkg
//  Description : Shared constants and parameter helpers for sync_fifo_fwft.
//  Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

    // Read-mode selectors for G_FWFT
    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int unsigned fifo_capacity(input int unsigned depth_log2);
        return 32'd1 << depth_log2;
    endfunction

    function automatic bit fifo_params_ok(
        input int unsigned depth_log2,
        input int          afull,
        input int          aempty,
        input int          fwft
    );
        return (afull >= 1)
            && (afull <= int'(fifo_capacity(depth_log2)))
            && (aempty < afull)
            && ((fwft == FIFO_STD) || (fwft == FIFO_FWFT));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft_ram.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ram
//  Description : Simple dual-port storage, synchronous write and registered
//                read with read-enable; read register clears on reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int G_WIDTH = 8,
    parameter int G_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_we,
    input  logic [G_DEPTH-1:0] i_waddr,
    input  logic [G_WIDTH-1:0] i_wdata,
    input  logic               i_re,
    input  logic [G_DEPTH-1:0] i_raddr,
    output logic [G_WIDTH-1:0] o_rdata
);

    localparam int unsigned c_WORDS = fifo_capacity(G_DEPTH);

    logic [G_WIDTH-1:0] r_mem [0:c_WORDS-1];
    logic [G_WIDTH-1:0] r_rdata_q;
    logic [G_WIDTH-1:0] w_rdata_d;

    // Storage itself is never reset; only the read register is.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        w_rdata_d = r_rdata_q;
        if (i_re) begin
            w_rdata_d = r_mem[i_raddr];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata_q <= '0;
        end else begin
            r_rdata_q <= w_rdata_d;
        end
    end

    assign o_rdata = r_rdata_q;

endmodule
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_fwft
//  Description : Single-clock FIFO with standard or first-word-fall-through
//                read, registered fill level, almost flags and sticky errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft
    import sync_fifo_pkg::*;
#(
    parameter int G_WIDTH  = 8,
    parameter int G_DEPTH  = 4,
    parameter int G_FWFT   = 0,
    parameter int G_AFULL  = 12,
    parameter int G_AEMPTY = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wr,
    input  logic [G_WIDTH-1:0] i_data,
    input  logic               i_rd,
    input  logic               i_clr_err,
    output logic [G_WIDTH-1:0] o_data,
    output logic               o_valid,
    output logic               o_full,
    output logic               o_empty,
    output logic               o_almost_full,
    output logic               o_almost_empty,
    output logic [G_DEPTH:0]   o_fill_level,
    output logic               o_overflow,
    output logic               o_underflow
);

    localparam int unsigned    c_CAP        = fifo_capacity(G_DEPTH);
    localparam logic [G_DEPTH:0] c_CAP_CNT  = (G_DEPTH+1)'(c_CAP);
    localparam logic [G_DEPTH:0] c_AFULL_CNT  = (G_DEPTH+1)'(G_AFULL);
    localparam logic [G_DEPTH:0] c_AEMPTY_CNT = (G_DEPTH+1)'(G_AEMPTY);
    localparam logic [G_DEPTH:0] c_ONE      = (G_DEPTH+1)'(1);

    generate
        if (!fifo_params_ok(G_DEPTH, G_AFULL, G_AEMPTY, G_FWFT)) begin : g_bad_params
            $error("sync_fifo_fwft: illegal G_AFULL/G_AEMPTY/G_FWFT combination");
        end
    endgenerate

    logic [G_DEPTH:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [G_DEPTH:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [G_DEPTH:0] r_count_q,  w_count_d;
    logic             r_valid_q,  w_valid_d;
    logic             r_ovf_q,    w_ovf_d;
    logic             r_udf_q,    w_udf_d;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_ok;
    logic             w_rd_ok;
    logic             w_ram_re;
    logic [G_DEPTH:0] w_mem_words;
    logic             w_mem_avail;

    assign w_full      = (r_count_q == c_CAP_CNT);
    assign w_empty     = (r_count_q == '0);
    assign w_wr_ok     = i_wr && !w_full;
    // Words committed to RAM and not yet fetched by the read port.
    assign w_mem_words = r_wr_ptr_q - r_rd_ptr_q;
    assign w_mem_avail = (w_mem_words != '0);

    generate
        if (G_FWFT == FIFO_FWFT) begin : g_fwft
            // The RAM read register doubles as the head register.
            always_comb begin
                w_rd_ok   = i_rd && r_valid_q;
                w_ram_re  = (!r_valid_q || w_rd_ok) && w_mem_avail;
                w_valid_d = r_valid_q;
                if (w_ram_re) begin
                    w_valid_d = 1'b1;
                end else if (w_rd_ok) begin
                    w_valid_d = 1'b0;
                end
            end
        end else begin : g_std
            // Without a head register, stored words equal RAM words.
            always_comb begin
                w_rd_ok   = i_rd && w_mem_avail;
                w_ram_re  = w_rd_ok;
                w_valid_d = w_rd_ok;
            end
        end
    endgenerate

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_wr_ok) begin
            w_wr_ptr_d = r_wr_ptr_q + c_ONE;
        end
        if (w_ram_re) begin
            w_rd_ptr_d = r_rd_ptr_q + c_ONE;
        end
        unique case ({w_wr_ok, w_rd_ok})
            2'b10:   w_count_d = r_count_q + c_ONE;
            2'b01:   w_count_d = r_count_q - c_ONE;
            default: w_count_d = r_count_q;
        endcase
        // Set beats clear when both happen in one cycle.
        w_ovf_d = (i_wr && w_full)   || (r_ovf_q && !i_clr_err);
        w_udf_d = (i_rd && !w_rd_ok) || (r_udf_q && !i_clr_err);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
            r_valid_q  <= 1'b0;
            r_ovf_q    <= 1'b0;
            r_udf_q    <= 1'b0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
            r_valid_q  <= w_valid_d;
            r_ovf_q    <= w_ovf_d;
            r_udf_q    <= w_udf_d;
        end
    end

    fifo_ram #(
        .G_WIDTH (G_WIDTH),
        .G_DEPTH (G_DEPTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_wr_ok),
        .i_waddr (r_wr_ptr_q[G_DEPTH-1:0]),
        .i_wdata (i_data),
        .i_re    (w_ram_re),
        .i_raddr (r_rd_ptr_q[G_DEPTH-1:0]),
        .o_rdata (o_data)
    );

    assign o_valid        = r_valid_q;
    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_almost_full  = (r_count_q >= c_AFULL_CNT);
    assign o_almost_empty = (r_count_q <= c_AEMPTY_CNT);
    assign o_fill_level   = r_count_q;
    assign o_overflow     = r_ovf_q;
    assign o_underflow    = r_udf_q;

endmodule
`default_nettype wire
